// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with halt/resume and watchdog.
// Latency: 4 cycles ALU/branch, 5 cycles load/store with zero-wait memory; each wait cycle adds one.
// Backpressure: memory req held until ack; a wait of TIMEOUT+1 cycles without ack locks into ERR.
module core_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        halt_req,
  input  logic        dec_rf_we,
  input  logic        dec_ld,
  input  logic        dec_dmem_we,
  input  logic        dec_br,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        fr_we,
  output logic        br_en,
  output logic        rf_we,
  output logic        pc_we,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q;
  logic [7:0]  wait_q;
  logic        halt_pend_q;
  logic [15:0] retired_q;

  logic        mem_op;
  assign mem_op = dec_ld | dec_dmem_we;

  // State, watchdog counter, pending-halt flag and retirement counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= 8'd0;
      halt_pend_q <= 1'b0;
      retired_q   <= 16'd0;
    end else begin
      // A halt request is remembered until the next instruction boundary;
      // in IDLE it is meaningless and in HALT it only blocks the resume.
      if (halt_req && (state_q != S_IDLE) && (state_q != S_HALT)) begin
        halt_pend_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_DECODE;
          end else if (wait_q == TIMEOUT_C) begin
            state_q <= S_ERR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (mem_op) begin
            state_q <= S_MEM;
            wait_q  <= 8'd0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            state_q <= S_WB;
          end else if (wait_q == TIMEOUT_C) begin
            state_q <= S_ERR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_WB: begin
          retired_q <= retired_q + 16'd1;
          if (halt_pend_q || halt_req) begin
            state_q <= S_HALT;
          end else begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
          end
        end
        S_HALT: begin
          if (run && !halt_req) begin
            halt_pend_q <= 1'b0;
            state_q     <= S_FETCH;
            wait_q      <= 8'd0;
          end
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_ERR;
        end
      endcase
    end
  end

  // Strobes and requests decoded from state and live inputs; suppressed while reset is asserted.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    fr_we    = 1'b0;
    br_en    = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_EXEC: begin
          fr_we = ~(dec_ld | dec_dmem_we | dec_br);
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = dec_dmem_we;
        end
        S_WB: begin
          rf_we = dec_rf_we;
          pc_we = 1'b1;
          br_en = dec_br;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  // Status flags follow the state directly.
  always_comb begin
    busy   = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
    halted = (state_q == S_HALT);
    err    = (state_q == S_ERR);
  end

  assign retired = retired_q;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the ONC-16 core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. It turns the instruction decoder's static control outputs into single-cycle write strobes, and runs the request/acknowledge handshakes to instruction and data memory. It sits between the decoder and the state elements: PC, IR, register file, flag register and data memory. It also provides halt/resume control, a memory-wait watchdog and a retired-instruction counter.

## Interface
- `TIMEOUT`, default 15: maximum wait cycles for a memory acknowledge before the error state is entered (1..255).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `run`  in  1  level; start from IDLE or resume from HALT.
- `halt_req`  in  1  pulse or level; request a stop at the next instruction boundary.
- `dec_rf_we`  in  1  decoder register-file write enable.
- `dec_ld`  in  1  decoder load indication (register-file write source = data memory).
- `dec_dmem_we`  in  1  decoder store indication.
- `dec_br`  in  1  decoder branch indication (flag decode enable).
- `imem_ack`  in  1  instruction memory data valid.
- `dmem_ack`  in  1  data memory access complete.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write; valid only with `dmem_req`.
- `ir_we`  out  1  IR load strobe.
- `fr_we`  out  1  flag register update strobe.
- `br_en`  out  1  PC takes the branch target at the WB `pc_we`.
- `rf_we`  out  1  register-file write strobe.
- `pc_we`  out  1  PC update strobe.
- `busy`  out  1  high in every state except IDLE, HALT and ERR.
- `halted`  out  1  high in HALT.
- `err`  out  1  high in ERR; sticky until reset.
- `retired`  out  16  count of completed instructions; wraps.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- State, wait counter, `halt_pend` and `retired` are registered. All other outputs decode combinationally from the state and current inputs.
- **IDLE:** all strobes 0. If `run`=1, go to FETCH.
- **FETCH:** `imem_req`=1.
  - On `imem_ack`: `ir_we`=1 in that same cycle, then go to DECODE.
- **DECODE:** no strobes; one cycle, then go to EXEC.
- **EXEC:**
  - `fr_we`=1 unless `dec_ld`, `dec_dmem_we` or `dec_br` is set.
  - Next state is MEM if `dec_ld` or `dec_dmem_we`, otherwise WB.
- **MEM:** `dmem_req`=1 and `dmem_we`=`dec_dmem_we`.
  - On `dmem_ack`: go to WB.
  - The load data capture is external and uses the same ack.
- **WB:**
  - `rf_we`=`dec_rf_we`, `pc_we`=1, `br_en`=`dec_br`.
  - `retired` increments by 1 and wraps from 0xFFFF to 0x0000.
  - Next state is HALT if `halt_pend` or `halt_req`, otherwise FETCH.
- **HALT:** `halted`=1.
  - If `run`=1 and `halt_req`=0: clear `halt_pend` and go to FETCH.
  - If `run`=1 and `halt_req`=1 together: stay in HALT.
- **`halt_pend`:** set by `halt_req` in any state other than IDLE and HALT; cleared on leaving HALT.
  - `halt_req` in IDLE is ignored.
  - `run` while `busy` is ignored.
- **Watchdog:**
  - The 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When the counter equals `TIMEOUT` and ack=0, go to ERR. An ack in that same cycle wins.
- **ERR:** all strobes 0, `err`=1. Only reset exits ERR.
- Acks received outside FETCH or MEM are ignored.
- The `dec_*` inputs are sampled only in EXEC, MEM and WB. They reflect the IR contents and are stable from DECODE onward.

## Timing
- Reset: after a clock edge with `rst_n`=0:
  - state is IDLE, `retired`=0, `halt_pend`=0, wait counter is 0;
  - every output is 0.
  - Reset taken mid-instruction aborts it; no strobe is issued in the reset cycle.
- Zero-wait latency, with ack in the first request cycle:
  - ALU/branch instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- Every strobe (`ir_we`, `fr_we`, `rf_we`, `pc_we`) is high for exactly one cycle per instruction at most.
- `dmem_req` and `dmem_we` stay stable until ack.
- From IDLE: `run` at edge N gives `imem_req`=1 in cycle N+1.
- A `halt_req` pulse in any cycle up to and including WB stops the core after that instruction. `halted`=1 from the cycle after WB.

## Test plan
- **ALU add with immediate acks:** reset, then `run` pulse; `dec_rf_we`=1, all other `dec_*`=0.
  - Required: states FETCH, DECODE, EXEC, WB, FETCH.
  - `ir_we`, `fr_we`, `rf_we`, `pc_we` each pulse once; `retired`=1 after WB.
- **Load with 3 wait cycles on `dmem_ack`:** `dec_ld`=1, `dec_rf_we`=1.
  - Required: `dmem_req` high 4 cycles with `dmem_we`=0.
  - `rf_we` and `pc_we` in the cycle after ack; `fr_we` never asserted.
- **Store:** `dec_dmem_we`=1, `dec_rf_we`=0.
  - Required: `dmem_we`=1 with `dmem_req`; `rf_we`=0 throughout; `pc_we` pulses once.
- **Branch:** `dec_br`=1.
  - Required: `fr_we`=0 in EXEC; `br_en`=1 and `pc_we`=1 together in WB.
- **Halt/resume:** `halt_req` pulse during DECODE.
  - Required: WB completes, then `halted`=1 and `busy`=0.
  - A later `run`=1 returns to FETCH the next cycle.
  - `run` and `halt_req` asserted together keep HALT.
- **Watchdog and wrap:**
  - With `TIMEOUT`=15 and `imem_ack` held at 0, `err`=1 in the cycle after the 16th FETCH cycle. `err` stays high until `rst_n`=0 clears it and returns to IDLE.
  - Separately, preloading 0xFFFF retirements wraps `retired` to 0x0000.
